// File: rtl/agu_sequencer.sv
// agu_sequencer: sequences one AGU transfer (accept, clear, load, per-beat enables, done).
// Optional AGU_SEQ_PERF_EN adds the perf_stall_cycles stall counter output.
module agu_sequencer #(
    parameter int LEN_W    = 16,
    parameter int FB_DEPTH = 64
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             tr_valid,
    output logic             tr_ready,
    input  logic [39:0]      tr_addresses,
    input  logic [3:0]       tr_control,
    input  logic [LEN_W-1:0] tr_length,
    input  logic             beat_stall,
    input  logic             abort,
    output logic [39:0]      latch_tr_addresses,
    output logic [3:0]       latch_tr_control,
    output logic             clear_agu,
    output logic             mem_gen_ldinit,
    output logic             byte_gen_ldinit,
    output logic             rc_gen_ldinit,
    output logic             mem_gen_enable,
    output logic             byte_gen_enable,
    output logic             fb_gen_enable,
    output logic             rc_gen_enable,
    output logic             busy,
    output logic             done,
`ifdef AGU_SEQ_PERF_EN
    output logic [31:0]      perf_stall_cycles,
`endif
    output logic [LEN_W-1:0] beat_count
);
    localparam int FB_W = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [39:0]      addr_q, addr_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [FB_W-1:0]  fb_q, fb_d;
    logic             abort_clr_q, abort_clr_d;
    logic             accept;
    logic             beat;

    // Next-state, descriptor capture and beat decode
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ctrl_d      = ctrl_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        fb_d        = fb_q;
        abort_clr_d = 1'b0;
        accept      = 1'b0;
        beat        = 1'b0;
        case (state_q)
            IDLE: if (tr_valid) begin
                accept  = 1'b1;
                addr_d  = tr_addresses;
                ctrl_d  = tr_control;
                len_d   = tr_length;
                cnt_d   = '0;
                fb_d    = '0;
                state_d = (tr_length == '0) ? DONE : CLEAR;
            end
            CLEAR: begin
                state_d     = abort ? IDLE : LOAD;
                abort_clr_d = abort;
            end
            LOAD: begin
                state_d     = abort ? IDLE : RUN;
                abort_clr_d = abort;
            end
            RUN: if (abort) begin
                state_d     = IDLE;
                abort_clr_d = 1'b1;
            end else if (!beat_stall) begin
                beat  = 1'b1;
                cnt_d = cnt_q + LEN_W'(1);
                fb_d  = fb_q + FB_W'(1);
                if (cnt_q == len_q - LEN_W'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            ctrl_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            fb_q        <= '0;
            abort_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ctrl_q      <= ctrl_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            fb_q        <= fb_d;
            abort_clr_q <= abort_clr_d;
        end
    end

    assign tr_ready           = (state_q == IDLE);
    assign busy               = (state_q != IDLE);
    assign done               = (state_q == DONE);
    assign clear_agu          = (state_q == CLEAR) | abort_clr_q;
    assign mem_gen_ldinit     = (state_q == LOAD);
    assign byte_gen_ldinit    = (state_q == LOAD);
    assign rc_gen_ldinit      = (state_q == LOAD);
    assign mem_gen_enable     = beat;
    assign byte_gen_enable    = beat;
    assign fb_gen_enable      = beat;
    assign rc_gen_enable      = beat & (fb_q == FB_W'(FB_DEPTH - 1));
    assign latch_tr_addresses = addr_q;
    assign latch_tr_control   = ctrl_q;
    assign beat_count         = cnt_q;

`ifdef AGU_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Saturating count of stalled RUN cycles, restarted on each accept
    always_comb begin
        perf_d = accept ? '0 :
                 (state_q == RUN && beat_stall && perf_q != '1) ? perf_q + 32'd1 : perf_q;
    end

    // Stall counter register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) perf_q <= '0;
        else            perf_q <= perf_d;
    end

    assign perf_stall_cycles = perf_q;
`endif
endmodule

// File: tb/tb_agu_sequencer.sv
// tb_agu_sequencer: randomized self-checking bench for agu_sequencer using a precomputed expected timeline.
module tb_agu_sequencer;
    localparam int FB = 64;

    logic        sys_clk, sys_rst_n;
    logic        tr_valid, tr_ready;
    logic [39:0] tr_addresses, latch_tr_addresses;
    logic [3:0]  tr_control, latch_tr_control;
    logic [15:0] tr_length, beat_count;
    logic        beat_stall, abort;
    logic        clear_agu, mem_gen_ldinit, byte_gen_ldinit, rc_gen_ldinit;
    logic        mem_gen_enable, byte_gen_enable, fb_gen_enable, rc_gen_enable;
    logic        busy, done;
`ifdef AGU_SEQ_PERF_EN
    logic [31:0] perf_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] prev_bc;
    logic [39:0] prev_la;
    logic [3:0]  prev_lc;

    typedef struct {
        logic v, st, ab;
        logic [39:0] a;
        logic [3:0] ct;
        logic [15:0] ln;
        logic clr, ld, en, rc, dn, rdy, bsy;
        logic [15:0] bc;
        logic [39:0] la;
        logic [3:0] lc;
    } cyc_t;

    agu_sequencer #(.LEN_W(16), .FB_DEPTH(FB)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .tr_valid(tr_valid), .tr_ready(tr_ready),
        .tr_addresses(tr_addresses), .tr_control(tr_control), .tr_length(tr_length),
        .beat_stall(beat_stall), .abort(abort),
        .latch_tr_addresses(latch_tr_addresses), .latch_tr_control(latch_tr_control),
        .clear_agu(clear_agu),
        .mem_gen_ldinit(mem_gen_ldinit), .byte_gen_ldinit(byte_gen_ldinit), .rc_gen_ldinit(rc_gen_ldinit),
        .mem_gen_enable(mem_gen_enable), .byte_gen_enable(byte_gen_enable),
        .fb_gen_enable(fb_gen_enable), .rc_gen_enable(rc_gen_enable),
        .busy(busy), .done(done),
`ifdef AGU_SEQ_PERF_EN
        .perf_stall_cycles(perf_stall_cycles),
`endif
        .beat_count(beat_count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A cycle while the sequencer is busy: junk descriptor on the bus that must be ignored
    function automatic cyc_t bcyc(input bit vb, input logic [15:0] bc, input logic [39:0] la, input logic [3:0] lc);
        cyc_t e;
        e = '{default: '0};
        e.v   = vb | 1'($urandom_range(0, 1));
        e.a   = {8'($urandom), 32'($urandom)};
        e.ct  = 4'($urandom);
        e.ln  = 16'($urandom);
        e.st  = 1'($urandom_range(0, 1));
        e.bsy = 1'b1;
        e.bc  = bc;
        e.la  = la;
        e.lc  = lc;
        return e;
    endfunction

    // ab_ph: 0 none, 1 abort in CLEAR, 2 abort in LOAD, 3 abort in RUN after ab_n beats
    task automatic run_tr(input logic [39:0] a, input logic [3:0] ct, input int len, input int pct,
                          input int sf, input int sn, input int ab_ph, input int ab_n, input bit vbusy);
        cyc_t q[$];
        cyc_t e;
        int k = 0, r = 0, nst = 0, exp_en = 0, exp_dn = 0, obs_en = 0, obs_dn = 0;
        bit aborted = 0;
        e = '{default: '0};
        e.v = 1; e.a = a; e.ct = ct; e.ln = 16'(len);
        e.ab = 1'($urandom_range(0, 1)); e.st = 1'($urandom_range(0, 1));
        e.rdy = 1; e.bc = prev_bc; e.la = prev_la; e.lc = prev_lc;
        q.push_back(e);
        if (len == 0) begin
            e = bcyc(vbusy, 0, a, ct); e.dn = 1; e.ab = 1'($urandom_range(0, 1)); exp_dn++;
            q.push_back(e);
        end else begin
            e = bcyc(vbusy, 0, a, ct); e.clr = 1; e.ab = (ab_ph == 1);
            q.push_back(e);
            aborted = (ab_ph == 1);
            if (!aborted) begin
                e = bcyc(vbusy, 0, a, ct); e.ld = 1; e.ab = (ab_ph == 2);
                q.push_back(e);
                aborted = (ab_ph == 2);
            end
            while (!aborted && r < 5000) begin
                e = bcyc(vbusy, 16'(k), a, ct);
                if (ab_ph == 3 && k == ab_n) begin
                    e.ab = 1;
                    if (e.st) nst++;
                    q.push_back(e);
                    aborted = 1;
                end else begin
                    e.st = (r >= sf && r < sf + sn) || ($urandom_range(0, 99) < pct);
                    if (e.st) nst++;
                    else begin
                        e.en = 1; e.rc = (k % FB == FB - 1); k++; exp_en++;
                    end
                    q.push_back(e);
                    r++;
                    if (k == len) begin
                        e = bcyc(vbusy, 16'(k), a, ct); e.dn = 1; e.ab = 1'($urandom_range(0, 1)); exp_dn++;
                        q.push_back(e);
                        break;
                    end
                end
            end
        end
        e = '{default: '0};
        e.rdy = 1; e.clr = aborted; e.bc = 16'(k); e.la = a; e.lc = ct;
        e.ab = 1'($urandom_range(0, 1)); e.st = 1'($urandom_range(0, 1));
        q.push_back(e);
        foreach (q[i]) begin
            tr_valid = q[i].v; tr_addresses = q[i].a; tr_control = q[i].ct; tr_length = q[i].ln;
            beat_stall = q[i].st; abort = q[i].ab;
            @(negedge sys_clk);
            check($sformatf("ctl c%0d", i),
                  {clear_agu, mem_gen_ldinit, byte_gen_ldinit, rc_gen_ldinit, mem_gen_enable,
                   byte_gen_enable, fb_gen_enable, rc_gen_enable, done, tr_ready, busy},
                  {q[i].clr, {3{q[i].ld}}, {3{q[i].en}}, q[i].rc, q[i].dn, q[i].rdy, q[i].bsy});
            check($sformatf("bc c%0d", i), beat_count, q[i].bc);
            check($sformatf("la c%0d", i), latch_tr_addresses, q[i].la);
            check($sformatf("lc c%0d", i), latch_tr_control, q[i].lc);
            obs_en += int'(fb_gen_enable);
            obs_dn += int'(done);
            @(posedge sys_clk);
            #1;
        end
        check("fb_pulses", obs_en, exp_en);
        check("done_pulses", obs_dn, exp_dn);
`ifdef AGU_SEQ_PERF_EN
        check("perf", perf_stall_cycles, nst);
`endif
        prev_bc = q[q.size() - 1].bc;
        prev_la = a;
        prev_lc = ct;
    endtask

    task automatic check_reset_vals(input string tag);
        check(tag,
              {clear_agu, mem_gen_ldinit, byte_gen_ldinit, rc_gen_ldinit, mem_gen_enable,
               byte_gen_enable, fb_gen_enable, rc_gen_enable, done, tr_ready, busy,
               beat_count, latch_tr_addresses, latch_tr_control},
              {11'b000_0000_0010, 16'd0, 40'd0, 4'd0});
`ifdef AGU_SEQ_PERF_EN
        check({tag, "_perf"}, perf_stall_cycles, 0);
`endif
    endtask

    initial begin
        sys_rst_n = 0; tr_valid = 0; tr_addresses = '0; tr_control = '0; tr_length = '0;
        beat_stall = 0; abort = 0;
        prev_bc = '0; prev_la = '0; prev_lc = '0;
        repeat (2) @(posedge sys_clk);
        #2 check_reset_vals("reset");
        sys_rst_n = 1;
        @(posedge sys_clk);
        #1;
        tr_valid = 1; tr_addresses = 40'h12_3456_789A; tr_control = 4'h7; tr_length = 16'd20;
        @(posedge sys_clk);
        #1 tr_valid = 0;
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        check("busy_pre_rst", {busy, fb_gen_enable}, 2'b11);
        sys_rst_n = 0;
        #1 check_reset_vals("async_rst");
        @(posedge sys_clk);
        #2 sys_rst_n = 1;
        run_tr(40'd102400, 4'b0010, 5, 0, 0, 0, 0, 0, 0);
        check("t2_bc", beat_count, 5);
        run_tr(40'hAB_CDEF_0123, 4'h5, 130, 0, 0, 0, 0, 0, 0);
        run_tr(40'h00_1111_2222, 4'h9, 4, 0, 1, 2, 0, 0, 0);
        run_tr(40'hFF_0000_FFFF, 4'hC, 20, 0, 0, 0, 3, 10, 0);
        check("t5_bc", beat_count, 10);
        run_tr(40'h55_AAAA_5555, 4'h3, 0, 0, 0, 0, 0, 0, 1);
        run_tr(40'h01_0203_0405, 4'h1, 7, 20, 0, 0, 1, 0, 1);
        run_tr(40'h06_0708_090A, 4'h2, 7, 20, 0, 0, 2, 0, 1);
        run_tr(40'h0B_0C0D_0E0F, 4'h4, 3, 0, 0, 0, 3, 2, 1);
        for (int t = 0; t < 40; t++) begin
            int len, ph;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 150));
            ph = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_tr({8'($urandom), 32'($urandom)}, 4'($urandom), len, int'($urandom_range(0, 50)),
                   0, 0, ph, int'($urandom_range(0, 150)), 1'($urandom_range(0, 1)));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
